// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle arithmetic/logic ops plus iterative one-bit-per-cycle shifts,
// with valid/ready handshakes on both the issue and result sides.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 out_valid_q, out_valid_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic [SHAMT_W-1:0]   shamt;
  logic                 accept;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  function automatic logic [WIDTH-1:0] alu_fn(input logic [2:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [WIDTH-1:0]        r;
    sa = a;
    sb = b;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, (sa < sb)};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] shift1(input logic [2:0] op,
                                              input logic [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] sv;
    logic [WIDTH-1:0]        r;
    sv = v;
    case (op)
      OP_SLL:  r = v << 1;
      OP_SRA:  r = sv >>> 1;
      default: r = v >> 1;
    endcase
    return r;
  endfunction

  assign in_ready  = rst_n && (state_q == S_IDLE);
  assign accept    = in_valid && in_ready;
  assign shamt     = src_b[SHAMT_W-1:0];
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = alu_control;
          if (!is_shift(alu_control)) begin
            result_d    = alu_fn(alu_control, src_a, src_b);
            zero_d      = (result_d == '0);
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else if (shamt == '0) begin
            result_d    = src_a;
            zero_d      = (src_a == '0);
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            result_d = src_a;
            cnt_d    = shamt;
            state_d  = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        result_d = shift1(op_q, result_q);
        cnt_d    = cnt_q - 1'b1;
        // Last shift step: result becomes final this edge, so flag it valid together.
        if (cnt_q == SHAMT_W'(1)) begin
          zero_d      = (result_d == '0);
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ADD;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
